adt7410_measure_fsm: RTL
========================

Name: adt7410_measure_fsm

Overview:
Responder end of the sensor-FSM/measure-FSM handshake for the slow ADT7410 temperature application. On a Start pulse it sets the ADT7410 to one-shot mode over the I2C master core, waits the conversion time, reads the 16-bit temperature register, and returns Byte1 (MSB) and Byte0 (LSB) with a Done pulse. Any I2C failure is reported with an Error pulse instead of Done. It sits between the sensor FSM and the I2C master core.

Parameters:
DataWidth, 8, width of one I2C byte and of Byte0_o/Byte1_o
I2CAddr, 7'h48, 7-bit ADT7410 slave address
ConfigValue, 8'h20, value written to config register 0x03 (one-shot mode)

Ports:
Reset_n_i  in  1  asynchronous reset, active low
Clk_i  in  1  clock, rising edge
Start_i  in  1  single-cycle start request from sensor FSM
Done_o  out  1  single-cycle pulse: measurement complete, bytes valid
Error_o  out  1  single-cycle pulse: I2C transfer failed
Byte0_o  out  DataWidth  temperature LSB (register 0x01)
Byte1_o  out  DataWidth  temperature MSB (register 0x00)
ParamCounterPreset_i  in  16  conversion wait in clock cycles
I2C_ReceiveSend_n_o  out  1  1 = read transaction, 0 = write transaction
I2C_ReadCount_o  out  DataWidth  bytes to read in a read transaction
I2C_StartProcess_o  out  1  single-cycle transaction start
I2C_Busy_i  in  1  core busy; rises the edge after StartProcess
I2C_FIFOReadNext_o  out  1  pop RX FIFO at next edge
I2C_FIFOWrite_o  out  1  push I2C_Data_o into TX FIFO at next edge
I2C_Data_o  out  DataWidth  TX FIFO write data
I2C_Data_i  in  DataWidth  RX FIFO head, valid combinationally
I2C_Error_i  in  1  core error flag, valid when Busy_i falls

Behaviour:
- Reset is Reset_n_i, asynchronous, active-low, with clock Clk_i. Reset puts the FSM in Idle, sets Byte0_o/Byte1_o to 0 and clears the timer.
- All control outputs are combinational from state. Their default is 0, I2C_Data_o is 0 and I2C_ReadCount_o is 0.
- Idle: Start_i=1 moves to CfgAddr. Start_i is ignored in every other state; there is no queueing.
- CfgAddr: FIFOWrite=1, Data={I2CAddr,1'b0}.
- CfgReg: FIFOWrite=1, Data=0x03.
- CfgVal: FIFOWrite=1, Data=ConfigValue.
- CfgGo: StartProcess=1, ReceiveSend_n=0. Next state is CfgWait.
- CfgWait: waits while Busy_i=1.
  - On Busy_i=0 with Error_i=1: Error_o=1 in this cycle, then Idle.
  - On Busy_i=0 with Error_i=0: load the timer with ParamCounterPreset_i and go to Conv.
- Conv: the timer decrements by 1 each cycle. When the timer equals 0, go to PtrAddr. A preset of 0 gives exactly one cycle in Conv. The maximum wait is 65536 cycles.
- PtrAddr: push {I2CAddr,0}. PtrReg: push 0x00. PtrGo: StartProcess, write.
- PtrWait: error handling is the same as CfgWait. With no error, go to RdAddr.
- RdAddr: push {I2CAddr,1'b1}.
- RdGo: StartProcess=1, ReceiveSend_n=1, ReadCount=2.
- RdWait: ReceiveSend_n=1, ReadCount=2 held. Error handling is the same as CfgWait. With no error, go to RdMSB.
- RdMSB: Byte1_o<=I2C_Data_i, FIFOReadNext=1.
- RdLSB: Byte0_o<=I2C_Data_i, FIFOReadNext=1.
- RdDone: Done_o=1, then Idle. Both bytes are already updated when Done_o is high.
- On Error_o, Byte0_o/Byte1_o keep their previous values. The RX FIFO is not drained.
- Done_o and Error_o are never high in the same cycle. Each pulse lasts exactly one cycle.
- Latency: for zero-length I2C busy phases and preset P, Start_i to Done_o is 15+P+1 cycles plus the three busy durations. The bench checks relative ordering, not absolute I2C timing.
- Unused state encodings return to Idle.
- Reset asserted mid-transaction returns to Idle immediately, with no Done or Error. The core's FIFOs are the core's concern.

Test Plan:
- Normal run: preset=5, core returns 0x0C then 0x80.
  - TX pushes must be 0x90,0x03,0x20 | 0x90,0x00 | 0x91.
  - ReadCount=2 on the read start.
  - Byte1_o=0x0C, Byte0_o=0x80, one Done_o pulse, no Error_o.
- Conversion timer: preset=0 gives exactly 1 Conv cycle; preset=1000 gives 1001 cycles from CfgWait exit to the PtrAddr push.
- Error on config write: I2C_Error_i=1 when Busy falls in CfgWait.
  - One Error_o pulse, return to Idle.
  - Bytes keep their old values, e.g. 0x0C/0x80 from a prior run.
  - No further FIFO pushes.
- Error on read: error in RdWait → Error_o pulse, no FIFOReadNext, no Done_o.
- Start_i pulsed during Conv and RdWait is ignored: exactly one Done_o per accepted Start. An immediate restart after Done is accepted.
- Reset_n_i low during PtrWait: all outputs at reset values, bytes = 0. A subsequent Start performs a full clean sequence.

Source files
------------

// File: rtl/adt7410_measure_fsm.sv
// adt7410_measure_fsm
//   Measure FSM for the slow ADT7410 temperature application. On a Start_i
//   pulse it writes the one-shot configuration through the I2C master core,
//   waits ParamCounterPreset_i+1 cycles for the conversion, sets the register
//   pointer to 0x00 and reads two bytes. The bytes come back on Byte1_o (MSB)
//   and Byte0_o (LSB), and the end of the measurement is signalled with a
//   one-cycle Done_o pulse. Any core error ends the sequence with a one-cycle
//   Error_o pulse instead of Done_o.
// Ports
//   Reset_n_i, Clk_i        : asynchronous active-low reset, rising-edge clock
//   Start_i                 : start request, sampled only in Idle
//   Done_o / Error_o        : one-cycle completion / failure pulses
//   Byte0_o / Byte1_o       : temperature LSB / MSB, held between runs
//   ParamCounterPreset_i    : conversion wait (cycles in Conv = preset + 1)
//   I2C_*                   : command, FIFO and status interface of the core
module adt7410_measure_fsm #(
  parameter int             DataWidth   = 8,
  parameter logic [6:0]     I2CAddr     = 7'h48,
  parameter logic [7:0]     ConfigValue = 8'h20
) (
  input  logic                 Reset_n_i,
  input  logic                 Clk_i,
  input  logic                 Start_i,
  output logic                 Done_o,
  output logic                 Error_o,
  output logic [DataWidth-1:0] Byte0_o,
  output logic [DataWidth-1:0] Byte1_o,
  input  logic [15:0]          ParamCounterPreset_i,
  output logic                 I2C_ReceiveSend_n_o,
  output logic [DataWidth-1:0] I2C_ReadCount_o,
  output logic                 I2C_StartProcess_o,
  input  logic                 I2C_Busy_i,
  output logic                 I2C_FIFOReadNext_o,
  output logic                 I2C_FIFOWrite_o,
  output logic [DataWidth-1:0] I2C_Data_o,
  input  logic [DataWidth-1:0] I2C_Data_i,
  input  logic                 I2C_Error_i
);

  localparam logic [DataWidth-1:0] AddrWr  = DataWidth'({I2CAddr, 1'b0});
  localparam logic [DataWidth-1:0] AddrRd  = DataWidth'({I2CAddr, 1'b1});
  localparam logic [DataWidth-1:0] RegCfg  = DataWidth'(8'h03);
  localparam logic [DataWidth-1:0] CfgVal  = DataWidth'(ConfigValue);
  localparam logic [DataWidth-1:0] RdCount = DataWidth'(2);

  typedef enum logic [4:0] {
    Idle, CfgAddr, CfgReg, CfgVal_s, CfgGo, CfgWait, Conv,
    PtrAddr, PtrReg, PtrGo, PtrWait,
    RdAddr, RdGo, RdWait, RdMSB, RdLSB, RdDone
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            timer_q, timer_d;
  logic [DataWidth-1:0]   byte0_q, byte0_d;
  logic [DataWidth-1:0]   byte1_q, byte1_d;

  // State and datapath registers
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= Idle;
      timer_q <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    case (state_q)
      Idle:     if (Start_i) state_d = CfgAddr;
      CfgAddr:  state_d = CfgReg;
      CfgReg:   state_d = CfgVal_s;
      CfgVal_s: state_d = CfgGo;
      CfgGo:    state_d = CfgWait;
      CfgWait: begin
        if (!I2C_Busy_i) begin
          if (I2C_Error_i) begin
            state_d = Idle;
          end else begin
            timer_d = ParamCounterPreset_i;
            state_d = Conv;
          end
        end
      end
      // Exit is tested before decrementing, so Conv lasts preset+1 cycles.
      Conv: begin
        if (timer_q == '0) state_d = PtrAddr;
        else               timer_d = timer_q - 16'd1;
      end
      PtrAddr:  state_d = PtrReg;
      PtrReg:   state_d = PtrGo;
      PtrGo:    state_d = PtrWait;
      PtrWait: begin
        if (!I2C_Busy_i) state_d = I2C_Error_i ? Idle : RdAddr;
      end
      RdAddr:   state_d = RdGo;
      RdGo:     state_d = RdWait;
      RdWait: begin
        if (!I2C_Busy_i) state_d = I2C_Error_i ? Idle : RdMSB;
      end
      RdMSB: begin
        byte1_d = I2C_Data_i;
        state_d = RdLSB;
      end
      RdLSB: begin
        byte0_d = I2C_Data_i;
        state_d = RdDone;
      end
      RdDone:   state_d = Idle;
      default:  state_d = Idle;
    endcase
  end

  // Control outputs, decoded from state only (Error_o also from core status)
  always_comb begin
    Done_o              = 1'b0;
    Error_o             = 1'b0;
    I2C_ReceiveSend_n_o = 1'b0;
    I2C_ReadCount_o     = '0;
    I2C_StartProcess_o  = 1'b0;
    I2C_FIFOReadNext_o  = 1'b0;
    I2C_FIFOWrite_o     = 1'b0;
    I2C_Data_o          = '0;
    case (state_q)
      CfgAddr:  begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = AddrWr; end
      CfgReg:   begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = RegCfg; end
      CfgVal_s: begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = CfgVal; end
      CfgGo:    I2C_StartProcess_o = 1'b1;
      CfgWait:  Error_o = !I2C_Busy_i && I2C_Error_i;
      PtrAddr:  begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = AddrWr; end
      PtrReg:   begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = '0; end
      PtrGo:    I2C_StartProcess_o = 1'b1;
      PtrWait:  Error_o = !I2C_Busy_i && I2C_Error_i;
      RdAddr:   begin I2C_FIFOWrite_o = 1'b1; I2C_Data_o = AddrRd; end
      RdGo: begin
        I2C_StartProcess_o  = 1'b1;
        I2C_ReceiveSend_n_o = 1'b1;
        I2C_ReadCount_o     = RdCount;
      end
      RdWait: begin
        I2C_ReceiveSend_n_o = 1'b1;
        I2C_ReadCount_o     = RdCount;
        Error_o             = !I2C_Busy_i && I2C_Error_i;
      end
      RdMSB:    I2C_FIFOReadNext_o = 1'b1;
      RdLSB:    I2C_FIFOReadNext_o = 1'b1;
      RdDone:   Done_o = 1'b1;
      default:  ;
    endcase
  end

  assign Byte0_o = byte0_q;
  assign Byte1_o = byte1_q;

endmodule
